// File: rtl/des_pkg.sv
// DES constants shared by the round sequencer: permutation/S-box tables, shift schedule,
// FSM state type and the bit-permutation helpers (table entries use DES 1-based MSB-first numbering).
package des_pkg;

  localparam int BLOCK_W  = 64;
  localparam int HALF_W   = 32;
  localparam int SUBKEY_W = 48;
  localparam int CD_W     = 56;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  // Each row is one S-box, indexed by {b5,b0,b4..b1} (row*16 + column).
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [3:0] sbox(input int n, input logic [5:0] b);
    int v;
    v = SBOX[n][{b[5], b[0], b[4:1]}];
    return v[3:0];
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    return (n == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    return (n == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_round_f.sv
// DES f-function: E-expand, subkey XOR, eight S-boxes, P. Purely combinational,
// no handshake; shared by every round of the sequencer.
module des_round_f
  import des_pkg::*;
(
  input  logic [HALF_W-1:0]   r,
  input  logic [SUBKEY_W-1:0] k,
  output logic [HALF_W-1:0]   f
);

  logic [SUBKEY_W-1:0] x;
  logic [HALF_W-1:0]   s;

  always_comb begin
    x = e_expand(r) ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) s[31-4*i -: 4] = sbox(i, x[47-6*i -: 6]);
    f = p_perm(s);
  end

endmodule

// File: rtl/des_round_sequencer.sv
// Iterative DES, one round per cycle: out_valid rises ROUNDS edges after accept; in_ready is low
// from accept until the result is retired, and the result is held until out_ready. Option: DES_KEY_CLEAR_EN.
module des_round_sequencer
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic [BLOCK_W-1:0] in_key,
  input  logic               in_decrypt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic [3:0]         round_idx
);

  state_t               state_q, state_d;
  logic [HALF_W-1:0]    l_q, r_q, f_out, r_nxt;
  logic [CD_W/2-1:0]    c_q, d_q, c_rot, d_rot;
  logic [SUBKEY_W-1:0]  subkey;
  logic [BLOCK_W-1:0]   out_q, ip_blk;
  logic [CD_W-1:0]      pc1_key;
  logic [3:0]           cnt_q;
  logic                 mode_q, last_round;

  assign ip_blk     = ip(in_block);
  assign pc1_key    = pc1(in_key);
  assign last_round = (cnt_q == 4'(ROUNDS - 1));

  // Decrypt walks the schedule backwards: round 0 uses the accept-time C/D (equal to C16/D16).
  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    if (!mode_q) begin
      c_rot = rotl28(c_q, SHIFTS[cnt_q]);
      d_rot = rotl28(d_q, SHIFTS[cnt_q]);
    end else if (cnt_q != 4'd0) begin
      c_rot = rotr28(c_q, SHIFTS[16 - int'(cnt_q)]);
      d_rot = rotr28(d_q, SHIFTS[16 - int'(cnt_q)]);
    end
  end

  assign subkey = pc2({c_rot, d_rot});

  des_round_f u_round_f (
    .r (r_q),
    .k (subkey),
    .f (f_out)
  );

  assign r_nxt = l_q ^ f_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ROUND;
      end
      ROUND: if (last_round) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      out_q  <= '0;
    end else if (state_q == IDLE && in_valid) begin
      l_q    <= ip_blk[63:32];
      r_q    <= ip_blk[31:0];
      c_q    <= pc1_key[55:28];
      d_q    <= pc1_key[27:0];
      mode_q <= in_decrypt;
      cnt_q  <= '0;
    end else if (state_q == ROUND) begin
      l_q <= r_q;
      r_q <= r_nxt;
      c_q <= c_rot;
      d_q <= d_rot;
      if (last_round) begin
        cnt_q <= '0;
        // Final swap folded in: FP is applied to R16||L16.
        out_q <= fp({r_nxt, r_q});
`ifdef DES_KEY_CLEAR_EN
        c_q    <= '0;
        d_q    <= '0;
        mode_q <= 1'b0;
`endif
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign out_block = out_q;
  assign round_idx = (state_q == ROUND) ? cnt_q : 4'd0;

endmodule
